// File: rtl/sqrt_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared sqrt unit.
// The master modport is the arbiter's view; slave is the view of the surrounding logic.
interface sqrt_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 64
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] x_in;
  logic [N-1:0]       done;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               err;
  logic [WIDTH-1:0]   sq_x;
  logic               sq_enable;
  logic [WIDTH-1:0]   sq_y;
  logic               sq_ready;

  modport master (
    input  req, x_in, sq_y, sq_ready,
    output done, y, busy, err, sq_x, sq_enable
  );

  modport slave (
    output req, x_in, sq_y, sq_ready,
    input  done, y, busy, err, sq_x, sq_enable
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt unit among N requesters, with a
// settle cycle against stale ready and a sticky timeout flag.
//
// state  | meaning
// IDLE   | waiting for any req; grants round-robin from ptr+1
// ISSUE  | sq_enable high for one cycle, wait counter cleared
// SETTLE | sq_ready ignored (may still be high from the previous result)
// WAIT   | wait for sq_ready or timeout
// DONE   | done[gnt] pulse, ptr <= gnt
module sqrt_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst,
  sqrt_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    gnt_q;
  logic [IW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     done_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sq_x_q;
  logic             sq_enable_q;
  logic             busy_q;
  logic             err_q;

  logic [IW-1:0]    gnt_d;
  logic             gnt_vld_d;
  int               idx;

  // First pending requester searching upward from ptr+1, wrapping at N.
  always_comb begin
    gnt_d     = '0;
    gnt_vld_d = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!gnt_vld_d && bus.req[idx]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= IW'(N - 1);
      cnt_q       <= '0;
      done_q      <= '0;
      y_q         <= '0;
      sq_x_q      <= '0;
      sq_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q      <= '0;
      sq_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            gnt_q       <= gnt_d;
            sq_x_q      <= bus.x_in[int'(gnt_d)*WIDTH +: WIDTH];
            sq_enable_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: state_q <= WAIT;
        WAIT: begin
          if (bus.sq_ready) begin
            y_q           <= bus.sq_y;
            done_q[gnt_q] <= 1'b1;
            state_q       <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // all-ones doubles as a quiet-NaN result for the requester
            err_q         <= 1'b1;
            y_q           <= '1;
            done_q[gnt_q] <= 1'b1;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          ptr_q   <= gnt_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.y         = y_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.sq_x      = sq_x_q;
  assign bus.sq_enable = sq_enable_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt unit plus an expected-result queue
// that is filled when requests are raised and drained on each done pulse.
module tb_sqrt_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sqrt_arbiter_if #(.N(N), .WIDTH(W)) ifc ();

  sqrt_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  typedef struct {
    int          idx;
    logic [63:0] x;
    logic [63:0] y;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     en_cnt = 0;
  int     en_cyc = 0;
  int     done_cnt = 0;
  int     last_lat = 0;
  int     lat = 4;
  bit     never_rdy = 1'b0;
  bit [N-1:0] hold = '0;

  function automatic logic [63:0] sqrt_ref(input logic [63:0] v);
    return $realtobits($sqrt($bitstoreal(v)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural sqrt unit: result after lat cycles, ready left high until
  // one cycle after the next enable.
  initial begin
    logic [63:0] m_x;
    int m_cnt, m_drop;
    m_x = '0; m_cnt = 0; m_drop = 0;
    ifc.sq_ready = 1'b0;
    ifc.sq_y = '0;
    forever begin
      @(negedge clk);
      if (m_drop > 0) begin
        m_drop--;
        if (m_drop == 0) ifc.sq_ready = 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0 && !never_rdy) begin
          ifc.sq_y = sqrt_ref(m_x);
          ifc.sq_ready = 1'b1;
        end
      end
      if (ifc.sq_enable) begin
        m_x = ifc.sq_x;
        m_cnt = lat;
        m_drop = 2;
      end
    end
  end

  function automatic logic [63:0] x_of(input int i);
    return ifc.x_in[i*W +: W];
  endfunction

  task automatic push(input int i, input bit tmo);
    exp_t e;
    e.idx = i;
    e.x = x_of(i);
    e.y = tmo ? 64'hffff_ffff_ffff_ffff : sqrt_ref(e.x);
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst && ifc.sq_enable) begin
      en_cnt++;
      en_cyc = cyc;
      if (q.size() == 0) chk("enable_without_request", 1, 0);
      else chk("sq_x", ifc.sq_x, q[0].x);
    end
    if (ifc.done != '0) begin
      done_cnt++;
      last_lat = cyc - en_cyc;
      chk("done_onehot", 64'($onehot(ifc.done)), 1);
      if (q.size() == 0) chk("done_without_request", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_vec", ifc.done, 64'(1 << e.idx));
        chk("y", ifc.y, e.y);
        if (!hold[e.idx]) ifc.req[e.idx] = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int d0 = done_cnt;
    for (int c = 0; c < budget && done_cnt < d0 + n; c++) step();
    chk("done_count", 64'(done_cnt - d0), 64'(n));
  endtask

  task automatic wait_enable(input int budget);
    int e0 = en_cnt;
    for (int c = 0; c < budget && en_cnt == e0; c++) step();
    chk("enable_seen", 64'(en_cnt - e0), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, ifc.done, 0);
    chk({tag, "_busy"}, 64'(ifc.busy), 0);
    chk({tag, "_err"}, 64'(ifc.err), 0);
    chk({tag, "_y"}, ifc.y, 0);
    chk({tag, "_sq_x"}, ifc.sq_x, 0);
    chk({tag, "_sq_enable"}, 64'(ifc.sq_enable), 0);
  endtask

  initial begin
    int e0;
    ifc.req = '0;
    ifc.x_in = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b1;

    // all four at once: grant order 0,1,2,3
    lat = 4;
    for (int i = 0; i < N; i++) ifc.x_in[i*W +: W] = $realtobits(real'(i * 7 + 3));
    for (int i = 0; i < N; i++) push(i, 1'b0);
    e0 = en_cnt;
    ifc.req = 4'b1111;
    wait_done(4, 200);
    chk("contention_enables", 64'(en_cnt - e0), 4);
    chk("contention_req_clear", ifc.req, 0);

    // single request; ready is still high from the previous result
    lat = 10;
    ifc.x_in[1*W +: W] = 64'h401bb14742b4b076;
    push(1, 1'b0);
    e0 = en_cnt;
    ifc.req = 4'b0010;
    wait_done(1, 100);
    chk("single_enables", 64'(en_cnt - e0), 1);
    chk("single_latency", 64'(last_lat), 64'(lat + 1));

    // fairness: req0 held, req2 joins after the first grant
    lat = 3;
    hold[0] = 1'b1;
    push(0, 1'b0);
    ifc.req[0] = 1'b1;
    wait_enable(20);
    ifc.req[2] = 1'b1;
    push(2, 1'b0);
    push(0, 1'b0);
    wait_done(2, 100);
    hold[0] = 1'b0;
    wait_done(1, 100);
    chk("fair_req_clear", ifc.req, 0);
    repeat (2) step();
    chk("fair_idle_busy", 64'(ifc.busy), 0);

    // timeout, with the request dropped after grant and x_in disturbed
    never_rdy = 1'b1;
    ifc.x_in[3*W +: W] = $realtobits(49.0);
    push(3, 1'b1);
    ifc.req[3] = 1'b1;
    wait_enable(20);
    ifc.req[3] = 1'b0;
    ifc.x_in[3*W +: W] = 64'hdead_beef_0000_1111;
    step();
    chk("sq_x_held", ifc.sq_x, $realtobits(49.0));
    chk("err_before_timeout", 64'(ifc.err), 0);
    wait_done(1, 100);
    chk("timeout_latency", 64'(last_lat), 18);
    chk("err_set", 64'(ifc.err), 1);
    never_rdy = 1'b0;
    push(1, 1'b0);
    ifc.req[1] = 1'b1;
    wait_done(1, 100);
    chk("err_sticky", 64'(ifc.err), 1);

    // reset while in WAIT: no done, then a fresh grant
    lat = 10;
    ifc.x_in[3*W +: W] = $realtobits(2.0);
    hold[3] = 1'b1;
    push(3, 1'b0);
    ifc.req[3] = 1'b1;
    wait_enable(20);
    repeat (3) step();
    e0 = done_cnt;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) step();
    chk("rst_no_done", 64'(done_cnt - e0), 0);
    q.delete();
    hold[3] = 1'b0;
    push(3, 1'b0);
    rst = 1'b1;
    wait_done(1, 100);
    chk("post_rst_latency", 64'(last_lat), 64'(lat + 1));
    chk("post_rst_err", 64'(ifc.err), 0);
    repeat (2) step();
    chk("final_busy", 64'(ifc.busy), 0);
    chk("final_queue_empty", 64'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters sharing one sqrt unit.
REQ-002 The block SHALL have parameter WIDTH, default 64, meaning the IEEE-754 double operand/result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles to wait for sq_ready after issue.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N bits: per-requester request level, held until its done pulse.
REQ-007 The block SHALL have port x_in, input, N*WIDTH bits: operand of requester i at bits [i*WIDTH +: WIDTH], stable while req[i]=1.
REQ-008 The block SHALL have port done, output, N bits: one-cycle pulse to the requester whose result is on y.
REQ-009 The block SHALL have port y, output, WIDTH bits: registered result, valid when any done bit is 1, held otherwise.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-012 The block SHALL have port sq_x, output, WIDTH bits: operand driven to the sqrt unit.
REQ-013 The block SHALL have port sq_enable, output, 1 bit: one-cycle start pulse to the sqrt unit.
REQ-014 The block SHALL have port sq_y, input, WIDTH bits: result from the sqrt unit.
REQ-015 The block SHALL have port sq_ready, input, 1 bit: sqrt unit result-valid level.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, SETTLE, WAIT, DONE.
REQ-017 IDLE: when req!=0, the block SHALL grant one requester by round-robin starting at index ptr+1 mod N, latch its index into gnt and its operand into sq_x, then go to ISSUE.
REQ-018 ISSUE: sq_enable SHALL be 1 for exactly this one cycle; next state SETTLE.
REQ-019 SETTLE: sq_ready SHALL be ignored for this one cycle so a stale ready from the previous operation is never accepted; next state WAIT.
REQ-020 WAIT: on sq_ready=1 the block SHALL register sq_y into y and go to DONE.
REQ-021 WAIT: a cycle counter, cleared in ISSUE, SHALL count WAIT cycles; on reaching TIMEOUT without sq_ready, err SHALL set, y SHALL load all-ones (quiet-NaN pattern) and the FSM SHALL go to DONE.
REQ-022 DONE: done[gnt] SHALL be 1 for this one cycle, ptr SHALL load gnt, next state IDLE.
REQ-023 Grant-to-done latency SHALL be 3 cycles plus the number of WAIT cycles in which sq_ready was 0.
REQ-024 Back-to-back: a requester re-asserting (or holding) req in the cycle after done SHALL be granted no earlier than the next IDLE cycle, and after every other pending requester (round-robin fairness).
REQ-025 A req bit dropping after grant SHALL NOT abort the operation; the done pulse SHALL still be issued.
REQ-026 Requests arriving while busy SHALL be held off until the next IDLE; no request is lost while its req stays high.
REQ-027 sq_x SHALL hold the latched operand from IDLE grant until the next grant, regardless of x_in changes.
REQ-028 At most one done bit SHALL be 1 in any cycle; done SHALL be 0 outside DONE.
REQ-029 err SHALL only be cleared by reset.

Reset
REQ-030 On rst=0, asynchronously: state IDLE, done=0, sq_enable=0, busy=0, err=0, y=0, sq_x=0, counter=0, gnt=0, ptr=N-1 (first grant favours requester 0).
REQ-031 Reset asserted mid-operation SHALL abandon the operation without a done pulse; after release the block SHALL arbitrate fresh from IDLE.

Verification
REQ-032 Single request: req=4'b0010, x_in[1]=0x401bb14742b4b076, sqrt model ready after 10 cycles -> one sq_enable pulse with sq_x=0x401bb14742b4b076, done=4'b0010 once, y=model result.
REQ-033 Contention: req=4'b1111 all at once -> grant order 0,1,2,3, exactly four sq_enable pulses, no overlap, each done pulse matching its operand.
REQ-034 Fairness: req[0] held permanently, req[2] asserted after first grant -> order 0,2,0,...; requester 2 never starved.
REQ-035 Stale ready: model leaves sq_ready=1 after previous result and drops it 1 cycle after enable -> second result not accepted until new sq_ready rise.
REQ-036 Timeout: TIMEOUT=16, model never asserts sq_ready -> done after 16 WAIT cycles, y=0xffffffffffffffff, err=1 until reset.
REQ-037 Reset in WAIT: rst=0 for 2 cycles mid-operation -> no done pulse, all outputs at reset values, next request served normally.
